mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and writeback stage of the pipelined MIPS core, directly upstream of the register file's write port. Accepts one instruction per handshake from EX/MEM, performs the word-sized data-memory access over a req/ack handshake, and drives `write_enable` / `write_address` / `write_data` as a one-cycle writeback pulse to the register file. It stalls upstream while a memory access is outstanding, aborts accesses that exceed a timeout, and flags misaligned addresses.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum wait cycles with `dmem_req` high before abort; 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  EX/MEM holds a valid instruction.
- `in_ready`  out  1  stage can accept; combinational, = (state == IDLE).
- `in_reg_write`  in  1  instruction writes a register.
- `in_mem_read`  in  1  load word.
- `in_mem_write`  in  1  store word; never set together with `in_mem_read`.
- `in_alu_result`  in  32  ALU result / effective address.
- `in_store_data`  in  32  store data.
- `in_dest`  in  5  destination register.
- `dmem_req`, `dmem_we`  out  1  memory request / write strobe (registered).
- `dmem_addr`, `dmem_wdata`  out  32  registered address / store data.
- `dmem_ack`  in  1  memory completion; sampled only while `dmem_req`=1.
- `dmem_rdata`  in  32  load data, valid with `dmem_ack`.
- `write_enable`  out  1  regfile write pulse (registered).
- `write_address`  out  5  regfile destination.
- `write_data`  out  32  regfile data.
- `addr_err`  out  1  one-cycle pulse: misaligned access dropped.
- `bus_err`  out  1  one-cycle pulse: access timed out.

## Operation
- States: IDLE, WAIT. Accept = `in_valid & in_ready`.
- IDLE, accept, no memory op: next edge loads `write_enable` = `in_reg_write & (in_dest != 0)`, `write_address` = `in_dest`, `write_data` = `in_alu_result`; stay IDLE.
- IDLE, accept, memory op with `in_alu_result[1:0] != 0`: instruction dropped, no request, `write_enable`=0, `addr_err`=1 next cycle; stay IDLE.
- IDLE, accept, aligned memory op: next edge `dmem_req`=1, `dmem_we`=`in_mem_write`, addr/wdata latched, dest/reg_write latched internally, wait counter cleared; go WAIT.
- WAIT, `dmem_ack`=1: next edge `dmem_req`=0, go IDLE; load → `write_enable` = latched reg_write & dest≠0, `write_data` = `dmem_rdata`; store → `write_enable`=0.
- WAIT, no ack: counter increments; on the edge where counter reaches `TIMEOUT`, drop request, `bus_err`=1 next cycle, no write, go IDLE. Ack on that same edge wins over timeout.
- `write_enable`, `addr_err`, `bus_err` are single-cycle pulses; cleared on every edge not setting them. `write_address`/`write_data` hold last value.
- Never writes register 0.

## Timing
- Reset (async): state IDLE, counter 0, all registered outputs 0; `in_ready`=1 after reset deasserts. Reset mid-WAIT abandons the access with no write and no error pulse.
- ALU instruction: accept edge N → `write_enable` high during cycle N+1; back-to-back accepts give back-to-back pulses.
- Load: accept edge N → `dmem_req` high from N+1; ack sampled at edge M (≥ N+1) → `write_enable` high during M+1. Minimum 2 cycles, `in_ready`=0 from N+1 through M.
- Regfile commits on the negedge of the `write_enable` cycle; same-cycle readers see the new value.
- Outputs `dmem_*` stable while `dmem_req`=1.

## Structure
- Shared `mips_pkg`: state encoding (IDLE/WAIT), `REG_ZERO` = 5'd0, `XLEN` = 32, `RADDR_W` = 5.
- Single module; the timeout counter is inline (8-bit, saturating not required since it clears on exit). No sub-module.

## Test plan
- Reset, then ALU op `in_alu_result`=0x0000_1234, dest=5 → `write_enable`=1 one cycle later, addr 5, data 0x1234; `in_ready` stays 1.
- Load addr 0x100, dest=8, ack after 3 wait cycles with rdata 0xDEAD_BEEF → `in_ready`=0 for 4 cycles, then one-cycle write of 0xDEADBEEF to r8.
- Store addr 0x104 data 0xCAFE, immediate ack → `dmem_we`=1 one cycle, no `write_enable`.
- Load addr 0x102 → no `dmem_req`, `addr_err` pulse, no write; ALU op with dest=0 → no write.
- Load with ack never arriving, `TIMEOUT`=15 → `bus_err` pulse after 15 wait cycles, `in_ready` returns to 1; ack on exactly the timeout edge → write, no `bus_err`.
- Assert `reset` during WAIT → outputs 0 immediately, no write, no error pulse; next instruction accepted normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: writeback-stage state encoding,
// datapath widths and the hard-wired zero register.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of EX/MEM input, data-memory handshake and register-file write port
// seen by the memory/writeback stage.
interface mem_wb_stage_if;
    import mips_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_reg_write;
    logic               in_mem_read;
    logic               in_mem_write;
    logic [XLEN-1:0]    in_alu_result;
    logic [XLEN-1:0]    in_store_data;
    logic [RADDR_W-1:0] in_dest;

    logic               dmem_req;
    logic               dmem_we;
    logic [XLEN-1:0]    dmem_addr;
    logic [XLEN-1:0]    dmem_wdata;
    logic               dmem_ack;
    logic [XLEN-1:0]    dmem_rdata;

    logic               write_enable;
    logic [RADDR_W-1:0] write_address;
    logic [XLEN-1:0]    write_data;
    logic               addr_err;
    logic               bus_err;

    // Environment side: EX/MEM, data memory and register file.
    modport master (
        output in_valid, in_reg_write, in_mem_read, in_mem_write,
        output in_alu_result, in_store_data, in_dest,
        input  in_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata,
        input  write_enable, write_address, write_data, addr_err, bus_err
    );

    modport slave (
        input  in_valid, in_reg_write, in_mem_read, in_mem_write,
        input  in_alu_result, in_store_data, in_dest,
        output in_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata,
        output write_enable, write_address, write_data, addr_err, bus_err
    );

endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: one instruction per handshake, word access
// over req/ack with timeout abort, one-cycle register-file write pulse.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);

    // The counter reaches TIMEOUT on the edge where it currently holds TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             r_state,     w_state_nxt;
    logic               r_req,       w_req_nxt;
    logic               r_we,        w_we_nxt;
    logic [XLEN-1:0]    r_addr,      w_addr_nxt;
    logic [XLEN-1:0]    r_wdata,     w_wdata_nxt;
    logic [RADDR_W-1:0] r_dest,      w_dest_nxt;
    logic               r_regwr,     w_regwr_nxt;
    logic [7:0]         r_cnt,       w_cnt_nxt;
    logic               r_wr_en,     w_wr_en_nxt;
    logic [RADDR_W-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic [XLEN-1:0]    r_wr_data,   w_wr_data_nxt;
    logic               r_addr_err,  w_addr_err_nxt;
    logic               r_bus_err,   w_bus_err_nxt;

    logic w_accept;
    logic w_mem_op;
    logic w_misaligned;

    assign w_accept     = bus.in_valid & (r_state == IDLE);
    assign w_mem_op     = bus.in_mem_read | bus.in_mem_write;
    assign w_misaligned = (bus.in_alu_result[1:0] != 2'b00);

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_dest_nxt     = r_dest;
        w_regwr_nxt    = r_regwr;
        w_cnt_nxt      = r_cnt;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_addr_err_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_mem_op) begin
                        w_wr_en_nxt   = bus.in_reg_write & (bus.in_dest != REG_ZERO);
                        w_wr_addr_nxt = bus.in_dest;
                        w_wr_data_nxt = bus.in_alu_result;
                    end else if (w_misaligned) begin
                        w_addr_err_nxt = 1'b1;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = bus.in_mem_write;
                        w_addr_nxt  = bus.in_alu_result;
                        w_wdata_nxt = bus.in_store_data;
                        w_dest_nxt  = bus.in_dest;
                        w_regwr_nxt = bus.in_reg_write;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // An ack arriving on the timeout edge still completes the access.
                if (bus.dmem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                    if (!r_we) begin
                        w_wr_en_nxt   = r_regwr & (r_dest != REG_ZERO);
                        w_wr_addr_nxt = r_dest;
                        w_wr_data_nxt = bus.dmem_rdata;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_req_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dest     <= '0;
            r_regwr    <= 1'b0;
            r_cnt      <= 8'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_dest     <= w_dest_nxt;
            r_regwr    <= w_regwr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_addr_err <= w_addr_err_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.dmem_req      = r_req;
    assign bus.dmem_we       = r_we;
    assign bus.dmem_addr     = r_addr;
    assign bus.dmem_wdata    = r_wdata;
    assign bus.write_enable  = r_wr_en;
    assign bus.write_address = r_wr_addr;
    assign bus.write_data    = r_wr_data;
    assign bus.addr_err      = r_addr_err;
    assign bus.bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage: a transaction-level model predicts
// each instruction's writeback, memory request or error pulse and its arrival time.
module tb_mem_wb_stage;

    localparam int TMO = 15;

    logic clk;
    logic reset;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        longint      t;
    } wb_t;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        longint      t;
    } req_t;

    wb_t    wb_q[$];
    req_t   req_q[$];
    longint aerr_q[$];
    longint berr_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction starting at a negedge; lat = no-ack wait edges before ack.
    task automatic do_instr(input bit rw, input bit mr, input bit mw,
                            input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] dest, input int lat, input logic [31:0] rd);
        longint t;
        int     low;
        int     guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_issue", {63'd0, bus.in_ready}, 64'd1);
        bus.dmem_ack      = 1'($urandom_range(0, 1));
        bus.dmem_rdata    = $urandom;
        bus.in_valid      = 1'b1;
        bus.in_reg_write  = rw;
        bus.in_mem_read   = mr;
        bus.in_mem_write  = mw;
        bus.in_alu_result = alu;
        bus.in_store_data = sd;
        bus.in_dest       = dest;
        @(posedge clk);
        t = longint'($time);
        if (!(mr || mw)) begin
            if (rw && dest != 5'd0) wb_q.push_back('{a: dest, d: alu, t: t + 5});
        end else if (alu[1:0] != 2'b00) begin
            aerr_q.push_back(t + 5);
        end else begin
            req_q.push_back('{a: alu, we: mw, wd: sd, t: t + 5});
            if (lat < TMO) begin
                if (mr && rw && dest != 5'd0)
                    wb_q.push_back('{a: dest, d: rd, t: t + 10 * (lat + 1) + 5});
            end else begin
                berr_q.push_back(t + 10 * TMO + 5);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!(mr || mw) || alu[1:0] != 2'b00) begin
            chk("ready_no_access", {63'd0, bus.in_ready}, 64'd1);
        end else begin
            low = 0;
            bus.dmem_ack = 1'b0;
            if (lat < TMO) begin
                for (int i = 0; i <= lat; i++) begin
                    if (i == lat) begin
                        bus.dmem_ack   = 1'b1;
                        bus.dmem_rdata = rd;
                    end
                    if (!bus.in_ready) low++;
                    @(negedge clk);
                end
                bus.dmem_ack = 1'b0;
                chk("ready_low_cycles", 64'(low), 64'(lat + 1));
            end else begin
                for (int i = 0; i < TMO; i++) begin
                    if (!bus.in_ready) low++;
                    @(negedge clk);
                end
                chk("ready_low_timeout", 64'(low), 64'(TMO));
            end
            chk("ready_after_access", {63'd0, bus.in_ready}, 64'd1);
        end
    endtask

    logic        prev_req;
    logic [31:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_wd;

    always @(negedge clk) begin
        if (reset) begin
            prev_req <= 1'b0;
        end else begin
            if (bus.write_enable) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    chk("wb_addr", 64'(bus.write_address), 64'(e.a));
                    chk("wb_data", 64'(bus.write_data), 64'(e.d));
                    chk("wb_time", 64'($time), 64'(e.t));
                end
            end
            if (bus.addr_err) begin
                if (aerr_q.size() == 0) chk("addr_err_unexpected", 64'd1, 64'd0);
                else chk("addr_err_time", 64'($time), 64'(aerr_q.pop_front()));
            end
            if (bus.bus_err) begin
                if (berr_q.size() == 0) chk("bus_err_unexpected", 64'd1, 64'd0);
                else chk("bus_err_time", 64'($time), 64'(berr_q.pop_front()));
            end
            if (bus.dmem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 64'd1, 64'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", 64'(bus.dmem_addr), 64'(r.a));
                    chk("req_we", 64'(bus.dmem_we), 64'(r.we));
                    chk("req_wdata", 64'(bus.dmem_wdata), 64'(r.wd));
                    chk("req_time", 64'($time), 64'(r.t));
                end
                cur_addr <= bus.dmem_addr;
                cur_we   <= bus.dmem_we;
                cur_wd   <= bus.dmem_wdata;
            end else if (bus.dmem_req) begin
                chk("req_stable", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata[30:0]},
                    {cur_we, cur_addr, cur_wd[30:0]});
            end
            if (!bus.dmem_req) chk("we_without_req", 64'(bus.dmem_we), 64'd0);
            prev_req <= bus.dmem_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rw;
        int          kind;
        int          lat;
        int          r;
        logic [31:0] alu;
        bus.in_valid      = 1'b0;
        bus.in_reg_write  = 1'b0;
        bus.in_mem_read   = 1'b0;
        bus.in_mem_write  = 1'b0;
        bus.in_alu_result = '0;
        bus.in_store_data = '0;
        bus.in_dest       = '0;
        bus.dmem_ack      = 1'b0;
        bus.dmem_rdata    = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_outs", {bus.dmem_req, bus.dmem_we, bus.write_enable, bus.addr_err, bus.bus_err},
            64'd0);
        chk("rst_data", {bus.dmem_addr, bus.write_data}, 64'd0);
        chk("rst_waddr", 64'(bus.write_address), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_instr(1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
        do_instr(1, 1, 0, 32'h0000_0100, 32'h0, 5'd8, 3, 32'hDEAD_BEEF);
        do_instr(0, 0, 1, 32'h0000_0104, 32'h0000_CAFE, 5'd0, 0, 32'h0);
        do_instr(1, 1, 0, 32'h0000_0102, 32'h0, 5'd9, 0, 32'h0);
        do_instr(1, 0, 0, 32'h0000_5555, 32'h0, 5'd0, 0, 32'h0);
        do_instr(1, 1, 0, 32'h0000_0200, 32'h0, 5'd10, TMO, 32'h0);
        do_instr(1, 1, 0, 32'h0000_0204, 32'h0, 5'd11, TMO - 1, 32'h1357_9BDF);
        do_instr(1, 0, 0, 32'hAAAA_0001, 32'h0, 5'd1, 0, 32'h0);
        do_instr(1, 0, 0, 32'hBBBB_0002, 32'h0, 5'd2, 0, 32'h0);

        // Reset while a load is waiting: access abandoned, nothing reported.
        bus.in_valid      = 1'b1;
        bus.in_reg_write  = 1'b1;
        bus.in_mem_read   = 1'b1;
        bus.in_mem_write  = 1'b0;
        bus.in_alu_result = 32'h0000_0300;
        bus.in_dest       = 5'd12;
        bus.dmem_ack      = 1'b0;
        @(posedge clk);
        req_q.push_back('{a: 32'h0000_0300, we: 1'b0, wd: bus.in_store_data,
                          t: longint'($time) + 5});
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midwait_rst_outs", {bus.dmem_req, bus.dmem_we, bus.write_enable, bus.addr_err,
            bus.bus_err}, 64'd0);
        chk("midwait_rst_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_instr(1, 0, 0, 32'h0000_7777, 32'h0, 5'd13, 0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            rw   = ($urandom_range(0, 3) != 0);
            r    = $urandom_range(0, 9);
            if (r < 6)       lat = $urandom_range(0, 4);
            else if (r == 6) lat = TMO - 1;
            else if (r == 7) lat = TMO;
            else             lat = $urandom_range(0, 2);
            alu = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: do_instr(rw, 0, 0, $urandom, $urandom, 5'($urandom_range(0, 31)), 0, 32'h0);
                1: do_instr(rw, 1, 0, alu, $urandom, 5'($urandom_range(0, 31)), lat, $urandom);
                2: do_instr(rw, 0, 1, alu, $urandom, 5'($urandom_range(0, 31)), lat, $urandom);
                default: do_instr(rw, ($urandom_range(0, 1) == 1), 1'b0,
                                  alu | 32'($urandom_range(1, 3)), $urandom,
                                  5'($urandom_range(0, 31)), 0, 32'h0);
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (TMO + 5) @(negedge clk);
        chk("wb_q_drained", 64'(wb_q.size()), 64'd0);
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("err_q_drained", 64'(aerr_q.size() + berr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
